// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: IF-stage bus between the fetch sequencer
// and the imem / decode / execute side.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              imem_rdy;
  logic              stall;
  logic              hlt;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] iaddr;
  logic [ADDR_W-1:0] pc_plus1;
  logic              if_valid;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  imem_rdy, stall, hlt,
    input  jmp, jmp_target,
    input  br_taken, br_target,
    output iaddr, pc_plus1,
    output if_valid, halted, retired
  );

  modport slave (
    output imem_rdy, stall, hlt,
    output jmp, jmp_target,
    output br_taken, br_target,
    input  iaddr, pc_plus1,
    input  if_valid, halted, retired
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage PC sequencer with redirect,
// stall, memory wait, halt and retired counter.
module fetch_ctrl #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = 16'h0000,
  parameter int              CNT_W     = 16
) (
  input logic         clk,
  input logic         rst_n,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    HALT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] iaddr_q;
  logic [ADDR_W-1:0] iaddr_d;
  logic [CNT_W-1:0]  ret_q;
  logic              halted_q;
  logic              active;
  logic              valid;

  assign active = (state_q == FETCH) ||
                  (state_q == WAIT);
  assign valid  = bus.imem_rdy & active & ~bus.stall;

  assign bus.iaddr    = iaddr_q;
  assign bus.pc_plus1 = iaddr_q + 1'b1;
  assign bus.if_valid = valid;
  assign bus.halted   = halted_q;
  assign bus.retired  = ret_q;

  // next state and next fetch address
  always_comb begin
    state_d = state_q;
    iaddr_d = iaddr_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, WAIT: begin
        if (!bus.imem_rdy) begin
          state_d = WAIT;
        end else if (bus.stall) begin
          state_d = FETCH;
        end else if (bus.hlt) begin
          state_d = HALT;
        end else if (bus.jmp) begin
          state_d = FETCH;
          iaddr_d = bus.jmp_target;
        end else if (bus.br_taken) begin
          state_d = FETCH;
          iaddr_d = bus.br_target;
        end else begin
          state_d = FETCH;
          iaddr_d = iaddr_q + 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // state, pc and halt flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      iaddr_q  <= RESET_VEC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iaddr_q  <= iaddr_d;
      halted_q <= (state_d == HALT);
    end
  end

  // saturating count of completed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else if (valid && !(&ret_q)) begin
      ret_q <= ret_q + 1'b1;
    end
  end

endmodule
